// File: rtl/merge_pkg.sv
`default_nettype none
// ============================================================================
// merge_pkg : FSM encoding, default sizing and group-field helpers
// Rev 1.0
// ============================================================================
package merge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int HEAD_NUM_DEF      = 12;
  localparam int INPUT_SHAPE_2_DEF = 4;
  localparam int CORE_NUM_DEF      = 2;
  localparam int NUM_WIDTH_DEF     = 3;
  localparam int GROUP_NUM_DEF     = HEAD_NUM_DEF / INPUT_SHAPE_2_DEF;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SEL_W_DEF = sel_width(CORE_NUM_DEF);

  // LSB of core's group field inside the packed core_grp bus
  function automatic int grp_lsb(input int core, input int num_width);
    return core * (num_width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, first eligible at/after ptr_i
// Rev 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [SW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [SW-1:0] win_o,
  output logic          any_o
);

  logic [N-1:0] w_elig;

  assign w_elig = req_i & ~mask_i;

  always_comb begin
    logic found;
    found   = 1'b0;
    grant_o = '0;
    win_o   = '0;
    for (int off = 0; off < N; off++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && w_elig[j] && (j == (int'(ptr_i) + off) % N)) begin
          grant_o[j] = 1'b1;
          win_o      = SW'(j);
          found      = 1'b1;
        end
      end
    end
    any_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/merge_scheduler.sv
`default_nettype none
// ============================================================================
// merge_scheduler : round-robin sequencing of core group results into merge
// Rev 1.0
// ============================================================================
module merge_scheduler
  import merge_pkg::*;
#(
  parameter int HEAD_NUM      = HEAD_NUM_DEF,
  parameter int INPUT_SHAPE_2 = INPUT_SHAPE_2_DEF,
  parameter int CORE_NUM      = CORE_NUM_DEF,
  parameter int NUM_WIDTH     = NUM_WIDTH_DEF
) (
  input  logic                              clk_p,
  input  logic                              rst_p,
  input  logic                              start_n,
  input  logic [CORE_NUM-1:0]               core_req_n,
  input  logic [CORE_NUM*(NUM_WIDTH+1)-1:0] core_grp,
  output logic [CORE_NUM-1:0]               core_grant_n,
  output logic [sel_width(CORE_NUM)-1:0]    merge_sel,
  output logic [NUM_WIDTH:0]                merge_num,
  output logic                              merge_valid_n,
  output logic                              merged_valid_n,
  input  logic                              out_ack_n,
  output logic                              busy,
  output logic                              err_dup
);

  localparam int GW        = NUM_WIDTH + 1;
  localparam int GROUP_NUM = HEAD_NUM / INPUT_SHAPE_2;
  localparam int SEL_W     = sel_width(CORE_NUM);

  state_e               state_q, state_d;
  logic [GROUP_NUM-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [CORE_NUM-1:0]  gnt_n_q, gnt_n_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [GW-1:0]        num_q, num_d;
  logic                 mv_n_q, mv_n_d;
  logic                 mgd_n_q, mgd_n_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic [GW-1:0]        w_grp [CORE_NUM];
  logic [CORE_NUM-1:0]  w_req, w_gnt;
  logic [SEL_W-1:0]     w_win;
  logic                 w_any, w_full, w_ok;
  logic [GW-1:0]        w_wgrp;
  logic [GROUP_NUM-1:0] w_slot;

  for (genvar gi = 0; gi < CORE_NUM; gi++) begin : g_grp
    assign w_grp[gi] = core_grp[grp_lsb(gi, NUM_WIDTH) +: GW];
  end

  // Once every slot has landed the layer is closed to further grants.
  assign w_full = &mask_q;
  assign w_req  = (state_q == ST_COLLECT && !w_full) ? ~core_req_n : '0;

  rr_arbiter #(
    .N  (CORE_NUM),
    .SW (SEL_W)
  ) u_arb (
    .req_i   (w_req),
    .mask_i  (~gnt_n_q),
    .ptr_i   (ptr_q),
    .grant_o (w_gnt),
    .win_o   (w_win),
    .any_o   (w_any)
  );

  always_comb begin
    w_wgrp = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      if (w_gnt[i]) w_wgrp = w_grp[i];
    end
  end

  always_comb begin
    w_slot = '0;
    for (int g = 0; g < GROUP_NUM; g++) begin
      w_slot[g] = (int'(w_wgrp) == g);
    end
  end

  // Out-of-range groups hit no slot, so they fall out as not-ok here too.
  assign w_ok = |(w_slot & ~mask_q);

  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      ptr_q   <= '0;
      gnt_n_q <= '1;
      sel_q   <= '0;
      num_q   <= '0;
      mv_n_q  <= 1'b1;
      mgd_n_q <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      gnt_n_q <= gnt_n_d;
      sel_q   <= sel_d;
      num_q   <= num_d;
      mv_n_q  <= mv_n_d;
      mgd_n_q <= mgd_n_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (!start_n)   state_d = ST_COLLECT;
      ST_COLLECT: if (w_full)     state_d = ST_DONE;
      ST_DONE:    if (!out_ack_n) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    gnt_n_d = '1;
    sel_d   = sel_q;
    num_d   = num_q;
    mv_n_d  = 1'b1;
    err_d   = 1'b0;
    if ((state_q == ST_IDLE && !start_n) || (state_q == ST_DONE && !out_ack_n)) begin
      mask_d = '0;
    end
    if (w_any) begin
      gnt_n_d = ~w_gnt;
      sel_d   = w_win;
      num_d   = w_wgrp;
      ptr_d   = (int'(w_win) == CORE_NUM - 1) ? '0 : w_win + 1'b1;
      if (w_ok) begin
        mv_n_d = 1'b0;
        mask_d = mask_q | w_slot;
      end else begin
        err_d  = 1'b1;
      end
    end
    mgd_n_d = (state_d != ST_DONE);
    busy_d  = (state_d != ST_IDLE);
  end

  assign core_grant_n   = gnt_n_q;
  assign merge_sel      = sel_q;
  assign merge_num      = num_q;
  assign merge_valid_n  = mv_n_q;
  assign merged_valid_n = mgd_n_q;
  assign busy           = busy_q;
  assign err_dup        = err_q;

endmodule
`default_nettype wire
